// File: rtl/coi_pkg.sv
// Shared definitions for the cascade-of-integrators decimator.
package coi_pkg;

  localparam int ORDER_MAX = 4;
  localparam int WARM_W    = 3;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_INC  = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_INC  = 2'd1,
    RUN_CONT = 2'd2
  } coi_state_e;

endpackage

// File: rtl/coi_comb.sv
// One comb stage: y = x - x_delayed, where the delay advances once per decimation.
module coi_comb
  import coi_pkg::*;
#(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [OUT_W-1:0] x_i,
  output logic [OUT_W-1:0] y_o
);

  logic [OUT_W-1:0] dly_q;
  logic [OUT_W-1:0] dly_d;

  assign y_o = x_i - dly_q;

  // Delay register next state: clear has priority, otherwise capture the stage input on enable.
  always_comb begin
    dly_d = dly_q;
    if (clr_i) begin
      dly_d = {OUT_W{1'b0}};
    end else if (en_i) begin
      dly_d = x_i;
    end else begin
      dly_d = dly_q;
    end
  end

  // Delay register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= {OUT_W{1'b0}};
    end else begin
      dly_q <= dly_d;
    end
  end

endmodule

// File: rtl/coi_cic_decimator.sv
// Sigma-delta bitstream decimator: integrator chain, sample counter, mode FSM,
// comb stages for continuous mode and a valid/ready output register.
module coi_cic_decimator
  import coi_pkg::*;
#(
  parameter int ORDER = 2,
  parameter int OUT_W = 32,
  parameter int OSR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             start,
  input  logic             mode,
  input  logic [OSR_W-1:0] osr,
  input  logic             din,
  input  logic             din_en,
  output logic             busy,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  coi_state_e       state_q, state_d;
  logic [OSR_W-1:0] osr_q, osr_d;
  logic [OSR_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [OUT_W-1:0] int_q [ORDER];
  logic [OUT_W-1:0] int_d [ORDER];
  logic [OUT_W-1:0] int_sum_s [ORDER];
  logic [OUT_W-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic [OUT_W-1:0] cin_s [ORDER];
  logic [OUT_W-1:0] c_s   [ORDER];

  logic             acc_s;
  logic             dec_pt_s;
  logic             warm_done_s;
  logic             new_res_s;
  logic             comb_en_s;
  logic             comb_clr_s;
  logic [OUT_W-1:0] res_s;
  logic [OSR_W-1:0] osr_eff_s;

  // In incremental mode no sample is taken while the final result is in flight.
  assign acc_s       = din_en && ((state_q == RUN_CONT) || ((state_q == RUN_INC) && !pend_q));
  assign dec_pt_s    = acc_s && (cnt_q == (osr_q - OSR_W'(1)));
  assign warm_done_s = (warm_q == WARM_W'(ORDER));
  assign new_res_s   = pend_q && !start && !clr &&
                       ((state_q == RUN_INC) || ((state_q == RUN_CONT) && warm_done_s));
  assign comb_en_s   = pend_q && (state_q == RUN_CONT);
  assign comb_clr_s  = clr || start;
  assign osr_eff_s   = (osr == {OSR_W{1'b0}}) ? OSR_W'(1) : osr;

  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;

  // Comb chain; stage 0 differentiates the last integrator, delays advance once per decimation.
  for (genvar k = 0; k < ORDER; k++) begin : g_comb
    if (k == 0) begin : g_first
      assign cin_s[k] = int_q[ORDER-1];
    end else begin : g_next
      assign cin_s[k] = c_s[k-1];
    end
    coi_comb #(
      .OUT_W(OUT_W)
    ) u_comb (
      .clk  (clk),
      .rst  (rst),
      .clr_i(comb_clr_s),
      .en_i (comb_en_s),
      .x_i  (cin_s[k]),
      .y_o  (c_s[k])
    );
  end

  // Direct-form integrator sums; each stage adds the freshly updated value of the previous one.
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      int_sum_s[k] = int_q[k];
    end
    int_sum_s[0] = int_q[0] + {{(OUT_W-1){1'b0}}, din};
    for (int k = 1; k < ORDER; k++) begin
      int_sum_s[k] = int_q[k] + int_sum_s[k-1];
    end
  end

  // Integrator next state: cleared on clr/start, updated only on accepted samples.
  always_comb begin
    for (int k = 0; k < ORDER; k++) begin
      int_d[k] = int_q[k];
      if (clr || start) begin
        int_d[k] = {OUT_W{1'b0}};
      end else if (acc_s) begin
        int_d[k] = int_sum_s[k];
      end else begin
        int_d[k] = int_q[k];
      end
    end
  end

  // Sample counter, decimation pipeline flag, warm-up counter and latched ratio.
  always_comb begin
    osr_d  = osr_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    warm_d = warm_q;
    if (clr) begin
      osr_d  = {OSR_W{1'b0}};
      cnt_d  = {OSR_W{1'b0}};
      pend_d = 1'b0;
      warm_d = {WARM_W{1'b0}};
    end else if (start) begin
      osr_d  = osr_eff_s;
      cnt_d  = {OSR_W{1'b0}};
      pend_d = 1'b0;
      warm_d = {WARM_W{1'b0}};
    end else begin
      pend_d = dec_pt_s;
      if (acc_s) begin
        cnt_d = dec_pt_s ? {OSR_W{1'b0}} : (cnt_q + OSR_W'(1));
      end else begin
        cnt_d = cnt_q;
      end
      if (comb_en_s && !warm_done_s) begin
        warm_d = warm_q + WARM_W'(1);
      end else begin
        warm_d = warm_q;
      end
    end
  end

  // Mode FSM: clr dominates start; incremental run ends on the edge its result is delivered.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = (mode == MODE_INC) ? RUN_INC : RUN_CONT;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        RUN_INC:  state_d = pend_q ? IDLE : RUN_INC;
        RUN_CONT: state_d = RUN_CONT;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Result selection: incremental takes the last integrator, continuous the last comb.
  always_comb begin
    res_s = c_s[ORDER-1];
    if (state_q == RUN_INC) begin
      res_s = int_q[ORDER-1];
    end else begin
      res_s = c_s[ORDER-1];
    end
  end

  // Output register with valid/ready handshake and sticky overrun.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    if (clr) begin
      dout_d       = {OUT_W{1'b0}};
      dout_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else if (new_res_s) begin
      dout_d       = res_s;
      dout_valid_d = 1'b1;
      if (dout_valid_q && !dout_ready) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      osr_q        <= {OSR_W{1'b0}};
      cnt_q        <= {OSR_W{1'b0}};
      pend_q       <= 1'b0;
      warm_q       <= {WARM_W{1'b0}};
      dout_q       <= {OUT_W{1'b0}};
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < ORDER; k++) begin
        int_q[k] <= {OUT_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      osr_q        <= osr_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      warm_q       <= warm_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      for (int k = 0; k < ORDER; k++) begin
        int_q[k] <= int_d[k];
      end
    end
  end

endmodule

// File: tb/tb_coi_cic_decimator.sv
// Self-checking bench: ORDER=2 and ORDER=3 instances share stimulus and are
// compared every cycle against a sample-history model, plus literal checks.
module tb_coi_cic_decimator;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        start;
  logic        mode;
  logic [15:0] osr;
  logic        din;
  logic        din_en;
  logic        ready;

  logic        busy_a, valid_a, ovr_a;
  logic [31:0] dout_a;
  logic        busy_b, valid_b, ovr_b;
  logic [31:0] dout_b;

  int n_checks;
  int n_pass;
  bit chk_on;

  // Model state: 0 idle, 1 incremental, 2 continuous
  int          m_state;
  int          hist[$];
  int          m_osr;
  bit          m_pend;
  int          m_decs;
  logic [31:0] m_pval [2];
  bit          m_pemit [2];
  bit          e_valid [2];
  logic [31:0] e_dout [2];
  bit          e_ovr [2];

  coi_cic_decimator #(.ORDER(2), .OUT_W(32), .OSR_W(16)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .mode(mode), .osr(osr),
    .din(din), .din_en(din_en), .busy(busy_a), .dout(dout_a),
    .dout_valid(valid_a), .dout_ready(ready), .overrun(ovr_a)
  );

  coi_cic_decimator #(.ORDER(3), .OUT_W(32), .OSR_W(16)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .mode(mode), .osr(osr),
    .din(din), .din_en(din_en), .busy(busy_b), .dout(dout_b),
    .dout_valid(valid_b), .dout_ready(ready), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic longint binom(input int n, input int k);
    longint r;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  // Incremental: weighted sum of all samples; continuous: boxcar^K FIR over the history.
  function automatic logic [31:0] mdl_value(input int o);
    int     k, n, hn;
    longint acc;
    int     h[64];
    int     t[64];
    k = o + 2;
    n = hist.size();
    acc = 0;
    if (m_state == 1) begin
      for (int i = 1; i <= n; i++) acc += longint'(hist[i-1]) * binom(n - i + k - 1, k - 1);
    end else begin
      for (int j = 0; j < 64; j++) h[j] = 0;
      h[0] = 1;
      hn = 1;
      for (int s = 0; s < k; s++) begin
        for (int j = 0; j < 64; j++) begin
          t[j] = 0;
          for (int u = 0; u < m_osr; u++) begin
            if (j - u >= 0 && j - u < hn) t[j] += h[j-u];
          end
        end
        hn = hn + m_osr - 1;
        h = t;
      end
      for (int j = 0; j < hn; j++) begin
        if (n - 1 - j >= 0) acc += longint'(h[j]) * hist[n-1-j];
      end
    end
    return acc[31:0];
  endfunction

  task automatic model_reset();
    m_state = 0;
    hist.delete();
    m_osr = 1;
    m_pend = 0;
    m_decs = 0;
    for (int o = 0; o < 2; o++) begin
      e_valid[o] = 0;
      e_dout[o] = 32'd0;
      e_ovr[o] = 0;
      m_pval[o] = 32'd0;
      m_pemit[o] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    bit acc;
    if (clr) begin
      model_reset();
    end else begin
      acc = din_en && (m_state == 2 || (m_state == 1 && !m_pend));
      for (int o = 0; o < 2; o++) begin
        if (m_pend && !start && m_pemit[o]) begin
          if (e_valid[o] && !ready) e_ovr[o] = 1;
          e_dout[o] = m_pval[o];
          e_valid[o] = 1;
        end else if (e_valid[o] && ready) begin
          e_valid[o] = 0;
        end
      end
      if (start) begin
        m_state = mode ? 1 : 2;
        m_osr = (osr == 16'd0) ? 1 : int'(osr);
        hist.delete();
        m_pend = 0;
        m_decs = 0;
      end else begin
        if (m_state == 1 && m_pend) m_state = 0;
        m_pend = 0;
        if (acc) begin
          hist.push_back(int'(din));
          if (hist.size() % m_osr == 0) begin
            m_decs++;
            m_pend = 1;
            for (int o = 0; o < 2; o++) begin
              m_pval[o] = mdl_value(o);
              m_pemit[o] = (m_state == 1) || (m_decs > o + 2);
            end
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy_a",  32'(busy_a),  (m_state != 0) ? 32'd1 : 32'd0);
      chk("busy_b",  32'(busy_b),  (m_state != 0) ? 32'd1 : 32'd0);
      chk("valid_a", 32'(valid_a), 32'(e_valid[0]));
      chk("valid_b", 32'(valid_b), 32'(e_valid[1]));
      chk("dout_a",  dout_a,       e_dout[0]);
      chk("dout_b",  dout_b,       e_dout[1]);
      chk("ovr_a",   32'(ovr_a),   32'(e_ovr[0]));
      chk("ovr_b",   32'(ovr_b),   32'(e_ovr[1]));
    end
  end

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic feed(input logic d, input logic en);
    din = d;
    din_en = en;
    do_cycle();
  endtask

  task automatic start_conv(input logic m, input int r);
    start = 1'b1;
    mode = m;
    osr = 16'(r);
    din = 1'b1;
    din_en = 1'b1;
    do_cycle();
    start = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; clr = 1'b0; start = 1'b0; mode = 1'b0;
    osr = 16'd0; din = 1'b0; din_en = 1'b0; ready = 1'b0;
    n_checks = 0; n_pass = 0;
    model_reset();
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dout", dout_a, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);

    // Incremental, all ones, osr=4
    ready = 1'b0;
    start_conv(1'b1, 4);
    repeat (4) feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    #1;
    chk("inc_ones_o2", dout_a, 32'd10);
    chk("inc_ones_o3", dout_b, 32'd20);
    chk("inc_valid", 32'(valid_a), 32'd1);
    chk("inc_busy_drop", 32'(busy_a), 32'd0);
    repeat (3) feed(1'b1, 1'b1);
    #1;
    chk("inc_ignored", dout_a, 32'd10);
    ready = 1'b1;
    repeat (2) feed(1'b0, 1'b0);

    // Incremental, all zeros
    start_conv(1'b1, 4);
    repeat (4) feed(1'b0, 1'b1);
    feed(1'b0, 1'b0);
    #1;
    chk("inc_zero_o2", dout_a, 32'd0);
    chk("inc_zero_o3", dout_b, 32'd0);
    repeat (2) feed(1'b0, 1'b0);

    // Continuous, all ones then alternating
    start_conv(1'b0, 4);
    repeat (12) feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    #1;
    chk("cont_ones_o2", dout_a, 32'd16);
    chk("cont_valid", 32'(valid_a), 32'd1);
    repeat (3) feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    #1;
    chk("cont_ones_o3", dout_b, 32'd64);
    start_conv(1'b0, 4);
    for (int i = 0; i < 20; i++) feed((i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
    feed(1'b0, 1'b0);
    #1;
    chk("cont_alt_o2", dout_a, 32'd8);
    chk("cont_alt_o3", dout_b, 32'd32);
    repeat (2) feed(1'b0, 1'b0);

    // Backpressure then clr
    ready = 1'b0;
    start_conv(1'b0, 4);
    repeat (16) feed(1'b1, 1'b1);
    feed(1'b0, 1'b0);
    #1;
    chk("bp_dout", dout_a, 32'd16);
    chk("bp_overrun", 32'(ovr_a), 32'd1);
    clr = 1'b1;
    feed(1'b0, 1'b0);
    clr = 1'b0;
    #1;
    chk("clr_overrun", 32'(ovr_a), 32'd0);
    chk("clr_valid", 32'(valid_a), 32'd0);

    // Abort after two samples, restart from zero
    ready = 1'b1;
    start_conv(1'b1, 4);
    repeat (2) feed(1'b1, 1'b1);
    start_conv(1'b1, 4);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    feed(1'b0, 1'b1);
    feed(1'b0, 1'b1);
    feed(1'b0, 1'b0);
    #1;
    chk("abort_o2", dout_a, 32'd7);
    chk("abort_o3", dout_b, 32'd16);

    // Asynchronous reset mid-run
    start_conv(1'b0, 4);
    repeat (5) feed(1'b1, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_dout", dout_a, 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_valid", 32'(valid_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // osr=0 behaves as 1
    start_conv(1'b1, 0);
    feed(1'b1, 1'b1);
    feed(1'b0, 1'b0);
    #1;
    chk("osr0_o2", dout_a, 32'd1);
    chk("osr0_o3", dout_b, 32'd1);
    repeat (2) feed(1'b0, 1'b0);

    // New result on the same edge as acceptance
    start_conv(1'b0, 1);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    feed(1'b1, 1'b1);
    feed(1'b0, 1'b1);
    feed(1'b1, 1'b1);
    #1;
    chk("same_edge_dout", dout_a, 32'd0);
    chk("same_edge_valid", 32'(valid_a), 32'd1);
    chk("same_edge_ovr", 32'(ovr_a), 32'd0);
    feed(1'b0, 1'b0);
    #1;
    chk("same_edge_next", dout_a, 32'd1);
    chk("same_edge_ovr2", 32'(ovr_a), 32'd0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
